// File: rtl/forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : forward_ctrl
// Purpose  : Hazard unit for a 5-stage pipeline. It drives the EX operand
//            forwarding selects and raises stall on load-use hazards and on
//            multi-cycle EX ops.
// Revision : 1.0 - initial release
// ============================================================================
module forward_ctrl #(
  parameter int MULT_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dest,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_multi,
  input  logic       id_flush,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
  output logic       stall,
  output logic       ex_busy
);

  localparam logic [5:0] c_LAT_M1 = 6'(MULT_LAT - 1);
  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b10;
  localparam logic [1:0] c_FWD_WB  = 2'b01;

  logic       r_ex_valid, r_ex_regwrite, r_ex_memread, r_ex_multi;
  logic [4:0] r_ex_rs, r_ex_rt, r_ex_dest;
  logic       r_mem_valid, r_mem_regwrite, r_mem_memread;
  logic [4:0] r_mem_dest;
  logic       r_wb_valid, r_wb_regwrite;
  logic [4:0] r_wb_dest;
  logic [5:0] r_cnt;

  logic w_ex_busy;
  logic w_load_use;
  logic w_id_live;
  logic w_mem_src;
  logic w_wb_src;

  assign w_ex_busy = (r_cnt != 6'd0);
  assign w_id_live = id_valid & ~id_flush;

  assign w_load_use = r_ex_valid & r_ex_memread & r_ex_regwrite &
                      (r_ex_dest != 5'd0) & id_valid &
                      ((id_uses_rs & (id_rs == r_ex_dest)) |
                       (id_uses_rt & (id_rt == r_ex_dest)));

  assign stall   = w_load_use | w_ex_busy;
  assign ex_busy = w_ex_busy;

  // A load in MEM has no ALU result yet, so it is only a source from WB.
  assign w_mem_src = r_mem_valid & r_mem_regwrite & ~r_mem_memread &
                     (r_mem_dest != 5'd0);
  assign w_wb_src  = r_wb_valid & r_wb_regwrite & (r_wb_dest != 5'd0);

  always_comb begin
    forwardA = c_FWD_RF;
    forwardB = c_FWD_RF;
    if (r_ex_valid) begin
      if (w_mem_src && (r_mem_dest == r_ex_rs))
        forwardA = c_FWD_MEM;
      else if (w_wb_src && (r_wb_dest == r_ex_rs))
        forwardA = c_FWD_WB;
      if (w_mem_src && (r_mem_dest == r_ex_rt))
        forwardB = c_FWD_MEM;
      else if (w_wb_src && (r_wb_dest == r_ex_rt))
        forwardB = c_FWD_WB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_multi     <= 1'b0;
      r_ex_rs        <= 5'd0;
      r_ex_rt        <= 5'd0;
      r_ex_dest      <= 5'd0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_dest     <= 5'd0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_dest      <= 5'd0;
      r_cnt          <= 6'd0;
    end else begin
      r_wb_valid    <= r_mem_valid;
      r_wb_regwrite <= r_mem_regwrite;
      r_wb_dest     <= r_mem_dest;
      if (w_ex_busy) begin
        // EX holds the multi-cycle op; MEM sees bubbles until it drains.
        r_mem_valid <= 1'b0;
        r_cnt       <= r_cnt - 6'd1;
      end else begin
        r_mem_valid    <= r_ex_valid;
        r_mem_regwrite <= r_ex_regwrite;
        r_mem_memread  <= r_ex_memread;
        r_mem_dest     <= r_ex_dest;
        if (w_load_use) begin
          r_ex_valid <= 1'b0;
        end else begin
          r_ex_valid    <= w_id_live;
          r_ex_rs       <= id_rs;
          r_ex_rt       <= id_rt;
          r_ex_dest     <= id_dest;
          r_ex_regwrite <= id_regwrite;
          r_ex_memread  <= id_memread;
          r_ex_multi    <= id_multi;
          if (w_id_live && id_multi)
            r_cnt <= c_LAT_M1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_forward_ctrl
// Purpose  : Directed self-checking bench for forward_ctrl (MULT_LAT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_regwrite, id_memread, id_multi, id_flush;
  logic [1:0] forwardA, forwardB;
  logic       stall, ex_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       bz;
  } exp_t;

  exp_t sb[$];

  forward_ctrl #(.MULT_LAT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_multi    (id_multi),
    .id_flush    (id_flush),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .stall       (stall),
    .ex_busy     (ex_busy)
  );

  always #5 clk = ~clk;

  task automatic drv(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                     input bit urs, input bit urt, input logic [4:0] d,
                     input bit rw, input bit mr, input bit mu, input bit fl);
    id_valid = v;     id_rs = rs;       id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt; id_dest = d;
    id_regwrite = rw; id_memread = mr;  id_multi = mu; id_flush = fl;
  endtask

  task automatic nop();
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d,
                     input bit fl = 0);
    drv(1, rs, rt, 1, 1, d, 1, 0, 0, fl);
  endtask

  task automatic ld(input logic [4:0] base, input logic [4:0] d);
    drv(1, base, 5'd0, 1, 0, d, 1, 1, 0, 0);
  endtask

  task automatic mul(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
    drv(1, rs, rt, 1, 1, d, 1, 0, 1, 0);
  endtask

  task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Expectation is queued when the ID inputs are applied, then checked
  // mid-cycle on the falling edge against the DUT outputs.
  task automatic chk(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic bz);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.st = st; e.bz = bz;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    cmp({e.tag, ".fwdA"},  forwardA, e.fa);
    cmp({e.tag, ".fwdB"},  forwardB, e.fb);
    cmp({e.tag, ".stall"}, {1'b0, stall},   {1'b0, e.st});
    cmp({e.tag, ".busy"},  {1'b0, ex_busy}, {1'b0, e.bz});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      chk(tag, 2'b00, 2'b00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    nop();
    @(posedge clk);
    #1;
    chk("reset", 2'b00, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;

    // add r3,r1,r2 ; sub r4,r3,r5
    alu(1, 2, 3);  chk("t27_add",  2'b00, 2'b00, 1'b0, 1'b0);
    alu(3, 5, 4);  chk("t27_sub",  2'b00, 2'b00, 1'b0, 1'b0);
    nop();         chk("t27_fwd",  2'b10, 2'b00, 1'b0, 1'b0);
    idle("t27_drain", 2);

    // add r3 ; nop ; or r6,r0,r3
    alu(1, 2, 3);  chk("t28_add",  2'b00, 2'b00, 1'b0, 1'b0);
    nop();         chk("t28_nop",  2'b00, 2'b00, 1'b0, 1'b0);
    alu(0, 3, 6);  chk("t28_or",   2'b00, 2'b00, 1'b0, 1'b0);
    nop();         chk("t28_fwd",  2'b00, 2'b01, 1'b0, 1'b0);
    idle("t28_drain", 1);

    // producers of r0 must never be forwarded, from MEM or from WB
    alu(1, 2, 0);  chk("r0_prod",  2'b00, 2'b00, 1'b0, 1'b0);
    alu(0, 0, 5);  chk("r0_c1",    2'b00, 2'b00, 1'b0, 1'b0);
    alu(0, 0, 5);  chk("r0_mem",   2'b00, 2'b00, 1'b0, 1'b0);
    nop();         chk("r0_wb",    2'b00, 2'b00, 1'b0, 1'b0);
    idle("r0_drain", 2);

    // lw r2 ; add r4,r2,r2
    ld(1, 2);      chk("t29_lw",    2'b00, 2'b00, 1'b0, 1'b0);
    alu(2, 2, 4);  chk("t29_stall", 2'b00, 2'b00, 1'b1, 1'b0);
    alu(2, 2, 4);  chk("t29_bub",   2'b00, 2'b00, 1'b0, 1'b0);
    nop();         chk("t29_fwd",   2'b01, 2'b01, 1'b0, 1'b0);
    idle("t29_drain", 1);

    // load dest matched by register fields the next instruction does not read
    ld(1, 2);                        chk("lu_lw",    2'b00, 2'b00, 1'b0, 1'b0);
    drv(1, 2, 2, 0, 0, 7, 1, 0, 0, 0); chk("lu_nouse", 2'b00, 2'b00, 1'b0, 1'b0);
    nop();                           chk("lu_memld", 2'b00, 2'b00, 1'b0, 1'b0);
    nop();                           chk("lu_nop",   2'b00, 2'b00, 1'b0, 1'b0);

    // load-use through rt only, with a flush that a stall must ignore
    ld(1, 2);        chk("lu_rt_lw",  2'b00, 2'b00, 1'b0, 1'b0);
    alu(5, 2, 4, 1); chk("lu_rt_stl", 2'b00, 2'b00, 1'b1, 1'b0);
    idle("lu_rt_drain", 2);

    // add r7 ; add r7 ; and r8,r7,r7
    alu(1, 2, 7);  chk("t30_a1",   2'b00, 2'b00, 1'b0, 1'b0);
    alu(3, 4, 7);  chk("t30_a2",   2'b00, 2'b00, 1'b0, 1'b0);
    alu(7, 7, 8);  chk("t30_and",  2'b00, 2'b00, 1'b0, 1'b0);
    nop();         chk("t30_fwd",  2'b10, 2'b10, 1'b0, 1'b0);
    idle("t30_drain", 2);

    // flushed add r9 must not become a forwarding source
    alu(1, 2, 9, 1); chk("fl_add",  2'b00, 2'b00, 1'b0, 1'b0);
    alu(9, 9, 5);    chk("fl_and",  2'b00, 2'b00, 1'b0, 1'b0);
    nop();           chk("fl_fwd",  2'b00, 2'b00, 1'b0, 1'b0);
    idle("fl_drain", 1);

    // add r10 ; mul r10,r10,r11 (4 cycles) ; add r4,r10,r6
    alu(1, 2, 10);  chk("t31_add",  2'b00, 2'b00, 1'b0, 1'b0);
    mul(10, 11, 10); chk("t31_mul", 2'b00, 2'b00, 1'b0, 1'b0);
    alu(10, 6, 4);  chk("t31_b1",   2'b10, 2'b00, 1'b1, 1'b1);
    alu(10, 6, 4);  chk("t31_b2",   2'b01, 2'b00, 1'b1, 1'b1);
    alu(10, 6, 4);  chk("t31_b3",   2'b00, 2'b00, 1'b1, 1'b1);
    alu(10, 6, 4);  chk("t31_last", 2'b00, 2'b00, 1'b0, 1'b0);
    nop();          chk("t31_fwd",  2'b10, 2'b00, 1'b0, 1'b0);
    idle("t31_drain", 2);

    // reset in cycle 2 of a mult, with a flushed add r9 in ID
    mul(1, 2, 10);   chk("t32_mul",  2'b00, 2'b00, 1'b0, 1'b0);
    alu(1, 2, 9, 1); chk("t32_busy", 2'b00, 2'b00, 1'b1, 1'b1);
    reset = 1'b1;
    chk("t32_rst", 2'b00, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    alu(1, 2, 9, 1); chk("t32_post", 2'b00, 2'b00, 1'b0, 1'b0);
    alu(9, 9, 5);    chk("t32_and",  2'b00, 2'b00, 1'b0, 1'b0);
    nop();           chk("t32_fwd",  2'b00, 2'b00, 1'b0, 1'b0);
    idle("t32_drain", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
